// File: rtl/mmm_pkg.sv
// mmm_pkg: shared definitions for the Montgomery datapath blocks.
//   csub_state_t    - control states of the serial conditional subtractor
//   DIGIT_W         - digit width processed per clock by the serial blocks
//   csub_cnt_width  - width of the digit counter for a given operand width
package mmm_pkg;

    typedef enum logic [1:0] {
        CSUB_IDLE = 2'd0,
        CSUB_RUN  = 2'd1,
        CSUB_DONE = 2'd2
    } csub_state_t;

    localparam int DIGIT_W = 4;

    // Counter width for WIDTH/DIGIT_W digits; never narrower than one bit.
    function automatic int csub_cnt_width(input int width);
        int w;
        w = $clog2(width / DIGIT_W);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/cond_sub_serial_sub4.sv
// sub4: combinational 4-bit borrow-lookahead subtractor.
//   {bout, d} = a - b - bin
// Computed as a + ~b + ~bin with generate/propagate lookahead, so the
// borrow-out is the complement of the adder carry-out.
// Ports:
//   a[3:0], b[3:0] - minuend, subtrahend
//   bin            - borrow in
//   d[3:0]         - difference
//   bout           - borrow out
module sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] nb_s;
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign nb_s = ~b;
    assign g_s  = a & nb_s;
    assign p_s  = a ^ nb_s;

    // Flattened lookahead carries: no ripple through the slice.
    assign c_s[0] = ~bin;
    assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

    assign d    = p_s ^ c_s[3:0];
    assign bout = ~c_s[4];

endmodule

// File: rtl/cond_sub_serial.sv
// cond_sub_serial: digit-serial conditional final subtractor.
// Returns S - M when S >= M, otherwise S (modulo 2^WIDTH). S - M is formed
// four bits per clock, LSB first, through one sub4 slice and a borrow register.
// Optional feature: define CSUB_SUB_TAKEN_EN to add the sub_taken output.
// Parameters:
//   WIDTH     - operand width; a multiple of 4 and at least 8
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - request, accepted only when idle
//   s_in       - accumulator S (WIDTH+1 bits, top bit is the prior carry-out)
//   m_in       - modulus M
//   busy       - high whenever not idle
//   done       - one-cycle pulse, result valid
//   result     - reduced value, held until the next accepted start
//   sub_taken  - (CSUB_SUB_TAKEN_EN only) 1 when S - M was selected
import mmm_pkg::*;

module cond_sub_serial #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH:0]   s_in,
    input  logic [WIDTH-1:0] m_in,
    output logic             busy,
    output logic             done,
`ifdef CSUB_SUB_TAKEN_EN
    output logic             sub_taken,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = csub_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    csub_state_t      state_r;
    logic [WIDTH-1:0] s_sh_r;
    logic [WIDTH-1:0] m_sh_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] s_keep_r;
    logic             s_top_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;

    logic [DIGIT_W-1:0] d_s;
    logic               bout_s;
    logic [WIDTH-1:0]   d_next_s;
    logic               take_s;

    sub4 u_sub4 (
        .a    (s_sh_r[DIGIT_W-1:0]),
        .b    (m_sh_r[DIGIT_W-1:0]),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // The last digit's difference and borrow are folded in directly so that
    // result is already registered on the first DONE cycle.
    assign d_next_s = {d_s, d_r[WIDTH-1:DIGIT_W]};
    assign take_s   = s_top_r | ~bout_s;

`ifdef CSUB_SUB_TAKEN_EN
    logic sub_taken_r;

    // Select flag, updated together with result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_taken_r <= 1'b0;
        end else if ((state_r == CSUB_RUN) && (cnt_r == LAST_CNT)) begin
            sub_taken_r <= take_s;
        end else begin
            sub_taken_r <= sub_taken_r;
        end
    end

    assign sub_taken = sub_taken_r;
`endif

    // Control FSM and digit-serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= CSUB_IDLE;
            s_sh_r   <= {WIDTH{1'b0}};
            m_sh_r   <= {WIDTH{1'b0}};
            d_r      <= {WIDTH{1'b0}};
            s_keep_r <= {WIDTH{1'b0}};
            s_top_r  <= 1'b0;
            borrow_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                CSUB_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        s_sh_r   <= s_in[WIDTH-1:0];
                        s_top_r  <= s_in[WIDTH];
                        m_sh_r   <= m_in;
                        s_keep_r <= s_in[WIDTH-1:0];
                        borrow_r <= 1'b0;
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= CSUB_RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= CSUB_IDLE;
                    end
                end
                CSUB_RUN: begin
                    s_sh_r   <= {{DIGIT_W{1'b0}}, s_sh_r[WIDTH-1:DIGIT_W]};
                    m_sh_r   <= {{DIGIT_W{1'b0}}, m_sh_r[WIDTH-1:DIGIT_W]};
                    d_r      <= d_next_s;
                    borrow_r <= bout_s;
                    cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    busy_r   <= 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        result_r <= take_s ? d_next_s : s_keep_r;
                        done_r   <= 1'b1;
                        state_r  <= CSUB_DONE;
                    end else begin
                        done_r   <= 1'b0;
                        state_r  <= CSUB_RUN;
                    end
                end
                CSUB_DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= CSUB_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= CSUB_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule
